reset_sequencer: RTL and testbench

//  Generalised reset generator that replaces the fixed two-flop push-button synchroniser.
//  - Synchronises the raw active-low push-button reset through a parametrised flop chain.
//  - Stretches the reset for a minimum hold time.
//  - Releases NUM_OUT reset domains one at a time in a staggered order (index 0 first).
//  - Accepts a software reset request from the core and reports the cause of the last reset.
//  - Sits at chip top, between the push-button input and every block reset.

---
 rtl/reset_sequencer.sv | 111 +++++++++++
 tb/tb_reset_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronised, stretched, staggered multi-domain reset generator with software reset and cause reporting
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int NUM_OUT     = 3,
  parameter int STAGGER     = 4
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);
  localparam int CMAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NUM_OUT + 1);

  typedef enum logic [1:0] {S_SYNC, S_STRETCH, S_RELEASE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUT-1:0]     rst_n_out_q, rst_n_out_d;
  logic                   rst_done_q, rst_done_d;
  logic [1:0]             rst_cause_q, rst_cause_d;

  // Next-state: SYNC enters STRETCH on the edge the last sync stage goes high, so release timing matches the software path
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_n_out_d = rst_n_out_q;
    rst_done_d  = rst_done_q;
    rst_cause_d = rst_cause_q;
    case (state_q)
      S_SYNC: begin
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = S_STRETCH;
          cnt_d   = CW'(1);
        end
      end
      S_STRETCH: begin
        if (cnt_q == CW'(STRETCH)) begin
          rst_n_out_d[0] = 1'b1;
          if (NUM_OUT == 1) begin
            rst_done_d = 1'b1;
            state_d    = S_RUN;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IW'(1);
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CW'(STAGGER - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int k = 0; k < NUM_OUT; k++)
            if (idx_q == IW'(k)) rst_n_out_d[k] = 1'b1;
          if (idx_q == IW'(NUM_OUT - 1)) begin
            rst_done_d = 1'b1;
            state_d    = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (sw_rst_req) begin
          rst_n_out_d = '0;
          rst_done_d  = 1'b0;
          rst_cause_d = 2'b10;
          cnt_d       = CW'(1);
          state_d     = S_STRETCH;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // State and outputs update on negedge clk; RST_n assertion clears everything without waiting for a clock
  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_SYNC;
      sync_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_n_out_q <= '0;
      rst_done_q  <= 1'b0;
      rst_cause_q <= 2'b01;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_n_out_q <= rst_n_out_d;
      rst_done_q  <= rst_done_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  assign rst_n_out = rst_n_out_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = rst_cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer at defaults plus a small-parameter instance
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       RST_n = 1'b0, sw_rst_req = 1'b0;
  logic [2:0] rst_n_out;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic       RST_n1 = 1'b0, sw1 = 1'b0;
  logic [0:0] rst_n_out1;
  logic       rst_done1;
  logic [1:0] rst_cause1;
  int         checks = 0, errors = 0, ne = 0;
  int         sb_e[$];
  logic [5:0] sb_v[$];
  int         b, e;

  reset_sequencer u0 (
    .clk(clk), .RST_n(RST_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out), .rst_done(rst_done), .rst_cause(rst_cause)
  );

  reset_sequencer #(.SYNC_STAGES(3), .STRETCH(1), .NUM_OUT(1), .STAGGER(4)) u1 (
    .clk(clk), .RST_n(RST_n1), .sw_rst_req(sw1),
    .rst_n_out(rst_n_out1), .rst_done(rst_done1), .rst_cause(rst_cause1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int edge_n, input logic [5:0] v);
    sb_e.push_back(edge_n);
    sb_v.push_back(v);
  endtask

  // r0 is the edge releasing bit 0; checks the edge before and the edge of each release
  task automatic push_seq(input int r0, input logic [1:0] cause);
    for (int k = 0; k < 3; k++) begin
      push(r0 + k*4 - 1, {cause, 1'b0, 3'((1 << k) - 1)});
      push(r0 + k*4, {cause, k == 2, 3'((1 << (k + 1)) - 1)});
    end
  endtask

  task automatic to_edge(input int t);
    while (ne < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    ne = ne + 1;
    #1;
    while (sb_e.size() > 0 && sb_e[0] <= ne) begin
      check($sformatf("edge%0d", sb_e[0]), {26'b0, rst_cause, rst_done, rst_n_out}, {26'b0, sb_v[0]});
      void'(sb_e.pop_front());
      void'(sb_v.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("por_hold", {rst_cause, rst_done, rst_n_out}, 6'b01_0_000);
    check("u1_hold", {rst_cause1, rst_done1, rst_n_out1}, 4'b01_0_0);
    // power-on release with an ignored sw request during STRETCH
    @(posedge clk);
    RST_n = 1'b1;
    b = ne;
    push_seq(b + 18, 2'b01);
    to_edge(b + 8);
    @(posedge clk) sw_rst_req = 1'b1;
    @(posedge clk) sw_rst_req = 1'b0;
    to_edge(b + 30);
    // software reset
    @(posedge clk) sw_rst_req = 1'b1;
    e = ne + 1;
    push(e, 6'b10_0_000);
    push_seq(e + 16, 2'b10);
    @(posedge clk) sw_rst_req = 1'b0;
    to_edge(e + 30);
    // asynchronous assertion between edges
    @(posedge clk);
    #2 RST_n = 1'b0;
    #1 check("async", {rst_cause, rst_done, rst_n_out}, 6'b01_0_000);
    repeat (2) @(posedge clk);
    RST_n = 1'b1;
    b = ne;
    push_seq(b + 18, 2'b01);
    to_edge(b + 30);
    // short glitch after bit 0 released
    @(posedge clk) RST_n = 1'b0;
    @(posedge clk) RST_n = 1'b1;
    b = ne;
    push(b + 17, 6'b01_0_000);
    push(b + 18, 6'b01_0_001);
    push(b + 19, 6'b01_0_001);
    to_edge(b + 19);
    @(posedge clk);
    #2 RST_n = 1'b0;
    #1 check("glitch", {rst_cause, rst_done, rst_n_out}, 6'b01_0_000);
    #1 RST_n = 1'b1;
    b = ne;
    push_seq(b + 18, 2'b01);
    to_edge(b + 30);
    // small-parameter instance
    @(posedge clk) RST_n1 = 1'b1;
    b = ne;
    to_edge(b + 3);
    check("p6_e3", {rst_cause1, rst_done1, rst_n_out1}, 4'b01_0_0);
    to_edge(b + 4);
    check("p6_e4", {rst_cause1, rst_done1, rst_n_out1}, 4'b01_1_1);
    to_edge(b + 6);
    @(posedge clk);
    sw1 = 1'b1;
    RST_n1 = 1'b0;
    to_edge(ne + 1);
    check("p6_win", {rst_cause1, rst_done1, rst_n_out1}, 4'b01_0_0);
    @(posedge clk);
    sw1 = 1'b0;
    RST_n1 = 1'b1;
    b = ne;
    to_edge(b + 4);
    check("p6_rel", {rst_cause1, rst_done1, rst_n_out1}, 4'b01_1_1);
    @(posedge clk) sw1 = 1'b1;
    e = ne + 1;
    to_edge(e);
    sw1 = 1'b0;
    check("p6_sw", {rst_cause1, rst_done1, rst_n_out1}, 4'b10_0_0);
    to_edge(e + 1);
    check("p6_swrel", {rst_cause1, rst_done1, rst_n_out1}, 4'b10_1_1);
    to_edge(ne + 2);
    check("sb_empty", sb_e.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
